// File: rtl/soc_addr_map_ctrl.sv
// Runtime-programmable SoC address map: shadow/active rule tables swapped atomically after the
// 2-stage lookup pipeline drains. Optional miss logging is built when SOC_ADDR_MAP_ERR_LOG_EN is defined.
module soc_addr_map_ctrl #(
   parameter int unsigned NumRules   = 16,
   parameter int unsigned NumSlaves  = 13,
   parameter int unsigned AddrWidth  = 64,
   parameter int unsigned DefaultIdx = 0,
   localparam int unsigned IdxW      = (NumSlaves > 1) ? $clog2(NumSlaves) : 1,
   localparam int unsigned RuleW     = (NumRules > 1) ? $clog2(NumRules) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_valid_i,
   input  logic [RuleW-1:0]     cfg_rule_i,
   input  logic [1:0]           cfg_field_i,
   input  logic [AddrWidth-1:0] cfg_wdata_i,
   input  logic                 cfg_commit_i,
   input  logic                 cfg_lock_i,
   output logic                 cfg_busy_o,
   output logic                 cfg_locked_o,
   input  logic                 lk_valid_i,
   output logic                 lk_ready_o,
   input  logic [AddrWidth-1:0] lk_addr_i,
   output logic                 dec_valid_o,
   input  logic                 dec_ready_i,
   output logic [IdxW-1:0]      dec_idx_o,
`ifdef SOC_ADDR_MAP_ERR_LOG_EN
   input  logic                 err_clr_i,
   output logic [AddrWidth-1:0] err_addr_o,
   output logic [15:0]          err_cnt_o,
`endif
   output logic                 dec_err_o
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDrain = 2'd1,
      StSwap  = 2'd2
   } state_e;

   logic [AddrWidth-1:0] sh_start_q  [NumRules];
   logic [AddrWidth-1:0] sh_start_d  [NumRules];
   logic [AddrWidth-1:0] sh_end_q    [NumRules];
   logic [AddrWidth-1:0] sh_end_d    [NumRules];
   logic [IdxW-1:0]      sh_idx_q    [NumRules];
   logic [IdxW-1:0]      sh_idx_d    [NumRules];
   logic [NumRules-1:0]  sh_en_q, sh_en_d;

   logic [AddrWidth-1:0] act_start_q [NumRules];
   logic [AddrWidth-1:0] act_start_d [NumRules];
   logic [AddrWidth-1:0] act_end_q   [NumRules];
   logic [AddrWidth-1:0] act_end_d   [NumRules];
   logic [IdxW-1:0]      act_idx_q   [NumRules];
   logic [IdxW-1:0]      act_idx_d   [NumRules];
   logic [NumRules-1:0]  act_en_q, act_en_d;

   state_e               state_q, state_d;
   logic                 locked_q, locked_d;
   logic                 s1_valid_q, s1_valid_d;
   logic [NumRules-1:0]  s1_match_q, s1_match_d;
   logic                 s2_valid_q, s2_valid_d;
   logic [IdxW-1:0]      s2_idx_q, s2_idx_d;
   logic                 s2_err_q, s2_err_d;

   logic                 blocked;
   logic                 s2_free;
   logic                 lk_fire;
   logic [NumRules-1:0]  match_vec;
   logic [IdxW-1:0]      enc_idx;
   logic                 enc_hit;

   assign blocked    = (state_q != StIdle);
   assign s2_free    = !s2_valid_q || dec_ready_i;
   assign lk_ready_o = !blocked && (!s1_valid_q || s2_free);
   assign lk_fire    = lk_valid_i && lk_ready_o;

   assign cfg_busy_o   = blocked;
   assign cfg_locked_o = locked_q;
   assign dec_valid_o  = s2_valid_q;
   assign dec_idx_o    = s2_idx_q;
   assign dec_err_o    = s2_err_q;

   // Shadow table writes; field 3 is reserved and dropped
   always_comb begin
      sh_start_d = sh_start_q;
      sh_end_d   = sh_end_q;
      sh_idx_d   = sh_idx_q;
      sh_en_d    = sh_en_q;
      if (cfg_valid_i && !locked_q) begin
         for (int unsigned r = 0; r < NumRules; r++) begin
            if (cfg_rule_i == RuleW'(r)) begin
               case (cfg_field_i)
                  2'd0: sh_start_d[r] = cfg_wdata_i;
                  2'd1: sh_end_d[r]   = cfg_wdata_i;
                  2'd2: begin
                     sh_en_d[r]  = cfg_wdata_i[IdxW];
                     sh_idx_d[r] = cfg_wdata_i[IdxW-1:0];
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Active table only changes in the single SWAP cycle, after the pipeline is empty
   always_comb begin
      act_start_d = act_start_q;
      act_end_d   = act_end_q;
      act_idx_d   = act_idx_q;
      act_en_d    = act_en_q;
      if (state_q == StSwap) begin
         act_start_d = sh_start_q;
         act_end_d   = sh_end_q;
         act_idx_d   = sh_idx_q;
         act_en_d    = sh_en_q;
      end
   end

   // Commit sequencing and sticky lock
   always_comb begin
      state_d  = state_q;
      locked_d = locked_q | cfg_lock_i;
      case (state_q)
         StIdle:  if (cfg_commit_i && !locked_q) state_d = StDrain;
         StDrain: if (!s1_valid_q && !s2_valid_q) state_d = StSwap;
         StSwap:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      match_vec = '0;
      for (int unsigned r = 0; r < NumRules; r++) begin
         match_vec[r] = act_en_q[r] && (lk_addr_i >= act_start_q[r]) && (lk_addr_i < act_end_q[r]);
      end
   end

   // Lowest-numbered matching rule wins
   always_comb begin
      enc_hit = |s1_match_q;
      enc_idx = IdxW'(DefaultIdx);
      for (int r = int'(NumRules) - 1; r >= 0; r--) begin
         if (s1_match_q[r]) enc_idx = act_idx_q[r];
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_match_d = s1_match_q;
      s2_valid_d = s2_valid_q;
      s2_idx_d   = s2_idx_q;
      s2_err_d   = s2_err_q;
      if (lk_fire) begin
         s1_valid_d = 1'b1;
         s1_match_d = match_vec;
      end else if (s2_free) begin
         s1_valid_d = 1'b0;
      end
      if (s2_free) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_idx_d = enc_idx;
            s2_err_d = !enc_hit;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         locked_q   <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_match_q <= '0;
         s2_valid_q <= 1'b0;
         s2_idx_q   <= IdxW'(DefaultIdx);
         s2_err_q   <= 1'b0;
         sh_en_q    <= '0;
         act_en_q   <= '0;
         for (int unsigned r = 0; r < NumRules; r++) begin
            sh_start_q[r]  <= '0;
            sh_end_q[r]    <= '0;
            sh_idx_q[r]    <= '0;
            act_start_q[r] <= '0;
            act_end_q[r]   <= '0;
            act_idx_q[r]   <= '0;
         end
      end else begin
         state_q     <= state_d;
         locked_q    <= locked_d;
         s1_valid_q  <= s1_valid_d;
         s1_match_q  <= s1_match_d;
         s2_valid_q  <= s2_valid_d;
         s2_idx_q    <= s2_idx_d;
         s2_err_q    <= s2_err_d;
         sh_en_q     <= sh_en_d;
         act_en_q    <= act_en_d;
         sh_start_q  <= sh_start_d;
         sh_end_q    <= sh_end_d;
         sh_idx_q    <= sh_idx_d;
         act_start_q <= act_start_d;
         act_end_q   <= act_end_d;
         act_idx_q   <= act_idx_d;
      end
   end

`ifdef SOC_ADDR_MAP_ERR_LOG_EN
   // The address only travels down the pipeline when something consumes it
   logic [AddrWidth-1:0] s1_addr_q, s1_addr_d;
   logic [AddrWidth-1:0] s2_addr_q, s2_addr_d;
   logic [AddrWidth-1:0] err_addr_q, err_addr_d;
   logic                 err_seen_q, err_seen_d;
   logic [15:0]          err_cnt_q, err_cnt_d;

   assign err_addr_o = err_addr_q;
   assign err_cnt_o  = err_cnt_q;

   always_comb begin
      s1_addr_d  = s1_addr_q;
      s2_addr_d  = s2_addr_q;
      err_addr_d = err_addr_q;
      err_seen_d = err_seen_q;
      err_cnt_d  = err_cnt_q;
      if (lk_fire) s1_addr_d = lk_addr_i;
      if (s2_free && s1_valid_q) s2_addr_d = s1_addr_q;
      if (err_clr_i) begin
         err_addr_d = '0;
         err_seen_d = 1'b0;
         err_cnt_d  = '0;
      end else if (s2_valid_q && dec_ready_i && s2_err_q) begin
         if (!err_seen_q) begin
            err_addr_d = s2_addr_q;
            err_seen_d = 1'b1;
         end
         if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_addr_q  <= '0;
         s2_addr_q  <= '0;
         err_addr_q <= '0;
         err_seen_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         s1_addr_q  <= s1_addr_d;
         s2_addr_q  <= s2_addr_d;
         err_addr_q <= err_addr_d;
         err_seen_q <= err_seen_d;
         err_cnt_q  <= err_cnt_d;
      end
   end
`endif

endmodule
